// File: rtl/histo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | histo_pkg : shared widths, FSM encoding and CDF-to-LUT scaling     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package histo_pkg;

   localparam int C_GRAY_LEVEL = 256;
   localparam int C_PIX_W      = 8;
   localparam int C_BIN_W      = 64;
   localparam int C_CDF_W      = 32;

   localparam logic [2:0] C_ST_IDLE  = 3'b001;
   localparam logic [2:0] C_ST_BUILD = 3'b010;
   localparam logic [2:0] C_ST_DONE  = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE  = C_ST_IDLE,
      ST_BUILD = C_ST_BUILD,
      ST_DONE  = C_ST_DONE
   } state_t;

   // Full 64-bit product so a saturated CDF cannot overflow before clamping.
   function automatic logic [C_PIX_W-1:0] cdf_to_lut(
      input logic [C_CDF_W-1:0] cdf,
      input logic [63:0]        scale,
      input int                 shift
   );
      logic [63:0] prod;
      prod = ({{(64-C_CDF_W){1'b0}}, cdf} * scale) >> shift;
      return (prod > 64'd255) ? {C_PIX_W{1'b1}} : prod[C_PIX_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/histo_eq_lut_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | histo_eq_lut_ram : 256x8 simple dual-port LUT, sync write,         |
// | registered read (read-during-write returns old content)            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module histo_eq_lut_ram
   import histo_pkg::*;
(
   input  logic               clk,
   input  logic               wr_en,
   input  logic [C_PIX_W-1:0] wr_addr,
   input  logic [C_PIX_W-1:0] wr_data,
   input  logic [C_PIX_W-1:0] rd_addr,
   output logic [C_PIX_W-1:0] rd_data
);

   logic [C_PIX_W-1:0] r_mem [0:C_GRAY_LEVEL-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
      rd_data <= r_mem[rd_addr];
   end

endmodule
`default_nettype wire

// File: rtl/histo_equalize_map.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | histo_equalize_map : builds an equalization LUT from a histogram   |
// | stream and maps pixels through it. HISTO_EQ_DBUF_EN: two banks.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module histo_equalize_map
   import histo_pkg::*;
#(
   parameter int IMG_WIDTH   = 480,
   parameter int IMG_HEIGHT  = 272,
   parameter int GRAY_LEVEL  = 256,
   parameter int SCALE_SHIFT = 24
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               pi_histo_vld,
   input  logic [C_BIN_W-1:0] pi_histo_data,
   input  logic               pi_hsync,
   input  logic               pi_vsync,
   input  logic               pi_data_vld,
   input  logic [C_PIX_W-1:0] pi_data,
   output logic               po_hsync,
   output logic               po_vsync,
   output logic               po_data_vld,
   output logic [C_PIX_W-1:0] po_data,
   output logic               po_lut_ready
);

   localparam logic [63:0] C_PIXELS = 64'(IMG_WIDTH) * 64'(IMG_HEIGHT);
   localparam logic [63:0] C_SCALE  = ((64'd255 << SCALE_SHIFT) + (C_PIXELS >> 1)) / C_PIXELS;
   localparam logic [C_PIX_W-1:0] C_LAST_BIN = C_PIX_W'(GRAY_LEVEL - 1);

   state_t              r_state, w_state_nxt;
   logic                r_hsync, r_vsync, r_dvld, r_lut_ready, r_map_lut;
   logic [C_PIX_W-1:0]  r_pix;
   logic [C_PIX_W-1:0]  r_bin_cnt, r_cdf_addr;
   logic [C_CDF_W-1:0]  r_cdf;
   logic                r_cdf_vld, r_all_in;
   logic                w_vs_rise, w_abort, w_beat_start, w_beat_build, w_beat;
   logic [C_CDF_W:0]    w_sum;
   logic [C_CDF_W-1:0]  w_cdf_base, w_cdf_nxt;
   logic                w_wr_en, w_wr_last;
   logic [C_PIX_W-1:0]  w_wr_data, w_map_q;
   logic                w_unused_histo_hi;

   assign w_unused_histo_hi = ^pi_histo_data[C_BIN_W-1:C_CDF_W];

   assign w_vs_rise    = pi_vsync & ~r_vsync;
   assign w_abort      = (r_state == ST_BUILD) && w_vs_rise;
   assign w_beat_start = (r_state == ST_IDLE) && pi_histo_vld;
   assign w_beat_build = (r_state == ST_BUILD) && pi_histo_vld && !r_all_in && !w_abort;
   assign w_beat       = w_beat_start || w_beat_build;

   assign w_cdf_base = w_beat_start ? '0 : r_cdf;
   assign w_sum      = {1'b0, w_cdf_base} + {1'b0, pi_histo_data[C_CDF_W-1:0]};
   assign w_cdf_nxt  = w_sum[C_CDF_W] ? {C_CDF_W{1'b1}} : w_sum[C_CDF_W-1:0];

   // Write stage sits one cycle behind the CDF register; an abort kills it.
   assign w_wr_en   = r_cdf_vld && (r_state == ST_BUILD) && !w_abort;
   assign w_wr_last = w_wr_en && (r_cdf_addr == C_LAST_BIN);
   assign w_wr_data = cdf_to_lut(r_cdf, C_SCALE, SCALE_SHIFT);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (pi_histo_vld) w_state_nxt = ST_BUILD;
         ST_BUILD: begin
            if (w_abort)        w_state_nxt = ST_IDLE;
            else if (w_wr_last) w_state_nxt = ST_DONE;
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hsync   <= 1'b0;
         r_vsync   <= 1'b0;
         r_dvld    <= 1'b0;
         r_pix     <= '0;
         r_map_lut <= 1'b0;
      end else begin
         r_hsync   <= pi_hsync;
         r_vsync   <= pi_vsync;
         r_dvld    <= pi_data_vld;
         r_pix     <= pi_data;
         r_map_lut <= r_lut_ready;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin_cnt  <= '0;
         r_cdf_addr <= '0;
         r_cdf      <= '0;
         r_cdf_vld  <= 1'b0;
         r_all_in   <= 1'b0;
      end else if (w_abort || (r_state == ST_DONE)) begin
         r_bin_cnt <= '0;
         r_cdf     <= '0;
         r_cdf_vld <= 1'b0;
         r_all_in  <= 1'b0;
      end else begin
         r_cdf_vld <= w_beat;
         if (w_beat) begin
            r_cdf      <= w_cdf_nxt;
            r_cdf_addr <= w_beat_start ? '0 : r_bin_cnt;
            r_bin_cnt  <= w_beat_start ? C_PIX_W'(1) : r_bin_cnt + C_PIX_W'(1);
            r_all_in   <= !w_beat_start && (r_bin_cnt == C_LAST_BIN);
         end
      end
   end

`ifdef HISTO_EQ_DBUF_EN
   logic               r_bank, r_rd_bank, r_swap_pend;
   logic [C_PIX_W-1:0] w_bank_q [2];

   // A finished table waits in the inactive bank until the next frame starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bank      <= 1'b0;
         r_rd_bank   <= 1'b0;
         r_swap_pend <= 1'b0;
         r_lut_ready <= 1'b0;
      end else begin
         r_rd_bank <= r_bank;
         if (r_state == ST_DONE) begin
            r_swap_pend <= 1'b1;
         end else if (w_beat_start) begin
            r_swap_pend <= 1'b0;
         end else if (r_swap_pend && w_vs_rise) begin
            r_swap_pend <= 1'b0;
            r_bank      <= ~r_bank;
            r_lut_ready <= 1'b1;
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      histo_eq_lut_ram u_ram (
         .clk     (clk),
         .wr_en   (w_wr_en && (r_bank != 1'(b))),
         .wr_addr (r_cdf_addr),
         .wr_data (w_wr_data),
         .rd_addr (pi_data),
         .rd_data (w_bank_q[b])
      );
   end

   assign w_map_q = r_rd_bank ? w_bank_q[1] : w_bank_q[0];
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      r_lut_ready <= 1'b0;
      else if (r_state == ST_DONE)  r_lut_ready <= 1'b1;
   end

   histo_eq_lut_ram u_ram (
      .clk     (clk),
      .wr_en   (w_wr_en),
      .wr_addr (r_cdf_addr),
      .wr_data (w_wr_data),
      .rd_addr (pi_data),
      .rd_data (w_map_q)
   );
`endif

   assign po_hsync     = r_hsync;
   assign po_vsync     = r_vsync;
   assign po_data_vld  = r_dvld;
   assign po_lut_ready = r_lut_ready;
   assign po_data      = !r_dvld ? '0 : (r_map_lut ? w_map_q : r_pix);

endmodule
`default_nettype wire

// File: tb/tb_histo_equalize_map.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_histo_equalize_map : directed table-driven bench for the LUT    |
// | builder and pixel mapper. Rev 1.0                                  |
// +--------------------------------------------------------------------+
module tb_histo_equalize_map;
   import histo_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pi_histo_vld = 1'b0;
   logic [63:0] pi_histo_data = '0;
   logic        pi_hsync = 1'b0, pi_vsync = 1'b0, pi_data_vld = 1'b0;
   logic [7:0]  pi_data = '0;
   logic        po_hsync, po_vsync, po_data_vld, po_lut_ready;
   logic [7:0]  po_data;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       hs;
      logic       vs;
      logic       vld;
      logic [7:0] pix;
      logic [7:0] exp;
   } vec_t;

   histo_equalize_map dut (
      .clk           (clk),
      .rst           (rst),
      .pi_histo_vld  (pi_histo_vld),
      .pi_histo_data (pi_histo_data),
      .pi_hsync      (pi_hsync),
      .pi_vsync      (pi_vsync),
      .pi_data_vld   (pi_data_vld),
      .pi_data       (pi_data),
      .po_hsync      (po_hsync),
      .po_vsync      (po_vsync),
      .po_data_vld   (po_data_vld),
      .po_data       (po_data),
      .po_lut_ready  (po_lut_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      pi_histo_vld  = 1'b0;
      pi_histo_data = '0;
      pi_hsync      = 1'b0;
      pi_vsync      = 1'b0;
      pi_data_vld   = 1'b0;
      pi_data       = '0;
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      pi_hsync    = v.hs;
      pi_vsync    = v.vs;
      pi_data_vld = v.vld;
      pi_data     = v.pix;
      step();
      check({tag, ".data"},  64'(po_data),     64'(v.exp));
      check({tag, ".vld"},   64'(po_data_vld), 64'(v.vld));
      check({tag, ".hsync"}, 64'(po_hsync),    64'(v.hs));
      check({tag, ".vsync"}, 64'(po_vsync),    64'(v.vs));
      pi_hsync    = 1'b0;
      pi_vsync    = 1'b0;
      pi_data_vld = 1'b0;
   endtask

   // kind 0: uniform 510/bin; kind 1: all pixels in bin 100; kind 2: CDF saturation
   task automatic send_bins(input int kind, input int n, input bit gaps);
      for (int b = 0; b < n; b++) begin
         pi_histo_vld = 1'b1;
         case (kind)
            0:       pi_histo_data = 64'd510;
            1:       pi_histo_data = (b == 100) ? 64'd130560 : 64'd0;
            default: pi_histo_data = (b == 0) ? 64'hDEAD_BEEF_FFFF_FFF0 :
                                     (b == 1) ? 64'h0000_0001_0000_0100 : 64'd0;
         endcase
         step();
         if (gaps && (b % 3 == 0)) begin
            pi_histo_vld = 1'b0;
            step();
         end
      end
      pi_histo_vld  = 1'b0;
      pi_histo_data = '0;
   endtask

   task automatic pulse_vsync();
      pi_vsync = 1'b1;
      step();
      pi_vsync = 1'b0;
      step();
   endtask

   task automatic finish_build(input logic ready_before, input string tag);
      repeat (6) step();
`ifdef HISTO_EQ_DBUF_EN
      check({tag, ".ready_pre_swap"}, 64'(po_lut_ready), 64'(ready_before));
`else
      check({tag, ".ready_done"}, 64'(po_lut_ready), 64'(1'b1 | ready_before));
`endif
      pulse_vsync();
      check({tag, ".ready"}, 64'(po_lut_ready), 64'd1);
   endtask

   function automatic logic [7:0] uni_exp(input int k);
      logic [63:0] v;
      v = (64'd510 * 64'(k + 1) * 64'd32768) >> 24;
      return (v > 64'd255) ? 8'd255 : v[7:0];
   endfunction

   initial begin
      vec_t pass_tab [6];
      vec_t uni_tab  [7];
      vec_t spike_tab[6];
      vec_t sat_tab  [3];
      int   uni_pix  [6];

      pass_tab[0] = '{1'b1, 1'b0, 1'b1, 8'h12, 8'h12};
      pass_tab[1] = '{1'b1, 1'b0, 1'b1, 8'hA5, 8'hA5};
      pass_tab[2] = '{1'b0, 1'b1, 1'b0, 8'h77, 8'h00};
      pass_tab[3] = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF};
      pass_tab[4] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
      pass_tab[5] = '{1'b0, 1'b0, 1'b1, 8'h3C, 8'h3C};

      uni_pix = '{0, 1, 100, 127, 254, 255};
      for (int i = 0; i < 6; i++)
         uni_tab[i] = '{1'b1, 1'b0, 1'b1, 8'(uni_pix[i]), uni_exp(uni_pix[i])};
      uni_tab[6] = '{1'b1, 1'b0, 1'b0, 8'd200, 8'd0};

      spike_tab[0] = '{1'b1, 1'b0, 1'b1, 8'd100, 8'd255};
      spike_tab[1] = '{1'b1, 1'b0, 1'b1, 8'd50,  8'd0};
      spike_tab[2] = '{1'b1, 1'b0, 1'b1, 8'd99,  8'd0};
      spike_tab[3] = '{1'b1, 1'b0, 1'b1, 8'd255, 8'd255};
      spike_tab[4] = '{1'b1, 1'b0, 1'b1, 8'd0,   8'd0};
      spike_tab[5] = '{1'b1, 1'b0, 1'b1, 8'd101, 8'd255};

      sat_tab[0] = '{1'b1, 1'b0, 1'b1, 8'd0,   8'd255};
      sat_tab[1] = '{1'b1, 1'b0, 1'b1, 8'd1,   8'd255};
      sat_tab[2] = '{1'b1, 1'b0, 1'b1, 8'd128, 8'd255};

      // Reset state
      rst = 1'b1;
      idle_inputs();
      repeat (3) step();
      check("reset.data",  64'(po_data),      64'd0);
      check("reset.vld",   64'(po_data_vld),  64'd0);
      check("reset.hsync", 64'(po_hsync),     64'd0);
      check("reset.vsync", 64'(po_vsync),     64'd0);
      check("reset.ready", 64'(po_lut_ready), 64'd0);
      rst = 1'b0;
      step();

      // Pass-through before any histogram
      for (int i = 0; i < 6; i++) apply_vec(pass_tab[i], "pass");
      check("pass.ready", 64'(po_lut_ready), 64'd0);

      // vsync rising edge after bin 120 aborts the build
      send_bins(0, 121, 1'b0);
      step();
      pulse_vsync();
      repeat (8) step();
      check("abort.ready", 64'(po_lut_ready), 64'd0);
      apply_vec('{1'b1, 1'b0, 1'b1, 8'h40, 8'h40}, "abort.pass");

      // Full uniform build after the abort
      send_bins(0, 256, 1'b0);
      finish_build(1'b0, "uni");
      for (int i = 0; i < 7; i++) apply_vec(uni_tab[i], "uni");

      // Single-bin spike with gaps between beats; old table visible until swap when banked
      send_bins(1, 256, 1'b1);
      repeat (6) step();
`ifdef HISTO_EQ_DBUF_EN
      apply_vec('{1'b1, 1'b0, 1'b1, 8'd50, 8'd50}, "spike.pre_swap");
`else
      apply_vec('{1'b1, 1'b0, 1'b1, 8'd50, 8'd0}, "spike.immediate");
`endif
      pulse_vsync();
      check("spike.ready", 64'(po_lut_ready), 64'd1);
      for (int i = 0; i < 6; i++) apply_vec(spike_tab[i], "spike");

      // CDF saturation: wrap-around would make LUT[1] small
      send_bins(2, 256, 1'b0);
      finish_build(1'b1, "sat");
      for (int i = 0; i < 3; i++) apply_vec(sat_tab[i], "sat");

      // Reset in the middle of a build
      send_bins(0, 201, 1'b0);
      pi_histo_vld  = 1'b1;
      pi_histo_data = 64'd510;
      pi_hsync      = 1'b1;
      pi_data_vld   = 1'b1;
      pi_data       = 8'd9;
      rst = 1'b1;
      step();
      check("rst_mid.data",  64'(po_data),      64'd0);
      check("rst_mid.vld",   64'(po_data_vld),  64'd0);
      check("rst_mid.hsync", 64'(po_hsync),     64'd0);
      check("rst_mid.ready", 64'(po_lut_ready), 64'd0);
      idle_inputs();
      step();
      rst = 1'b0;
      repeat (4) step();
      apply_vec('{1'b1, 1'b0, 1'b1, 8'd77, 8'd77}, "post_rst.pass");
      check("post_rst.ready", 64'(po_lut_ready), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
